// File: rtl/prio_arbiter_n_pkg.sv
// Shared types and helpers for the registered N-request priority arbiter.
package prio_arb_pkg;

    localparam int unsigned MAX_N = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot vector with bit idx set; all zero when idx is outside 0..n-1.
    function automatic logic [MAX_N-1:0] idx_to_onehot(input int unsigned idx,
                                                       input int unsigned n);
        logic [MAX_N-1:0] v;
        v = MAX_N'(1) << idx;
        if (idx >= n) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/prio_arbiter_n_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_arbiter_n_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic [N-1:0] req;
    logic         grant_ack;
    logic         grant_valid;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_onehot;
    logic         idle;

    modport master (
        output req, grant_ack,
        input  grant_valid, grant_idx, grant_onehot, idle
    );

    modport slave (
        input  req, grant_ack,
        output grant_valid, grant_idx, grant_onehot, idle
    );
endinterface

// File: rtl/prio_enc_n.sv
// Combinational N-to-W priority encoder; highest set index wins.
module prio_enc_n #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] in_c,
    output logic [W-1:0] idx_c,
    output logic         any_c
);

    // Later (higher) indices overwrite earlier ones.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_c[W'(i)]) begin
                idx_c = W'(i);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-request priority arbiter holding each grant until acknowledged.
// Build option: define PRIO_ARB_RR_EN for round-robin selection; otherwise
// fixed priority (highest index wins).
module prio_arbiter_n
    import prio_arb_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_arbiter_n_if.slave  bus
);

    localparam int unsigned W = $clog2(N);

    state_t       state_q, state_d;
    logic         grant_valid_q, grant_valid_d;
    logic [W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0] grant_onehot_q, grant_onehot_d;
    logic         idle_q;

    logic [N-1:0] cand_c;
    logic [N-1:0] enc_in_c;
    logic [W-1:0] enc_idx_c;
    logic         enc_any_c;
    logic [W-1:0] win_idx_c;

    // Candidate set: the current grant is masked out on an ack cycle.
    always_comb begin
        cand_c = bus.req;
        if (state_q == ST_GRANT && bus.grant_ack) begin
            cand_c = bus.req & ~grant_onehot_q;
        end
    end

`ifdef PRIO_ARB_RR_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Rotate so that ptr lands on the encoder's top (highest-priority) bit.
    always_comb begin
        int unsigned s;
        s        = 0;
        enc_in_c = '0;
        for (int unsigned j = 0; j < N; j++) begin
            s = 32'(ptr_q) + j + 1;
            if (s >= N) begin
                s = s - N;
            end
            enc_in_c[W'(j)] = cand_c[W'(s)];
        end
    end

    // Map the encoder's rotated index back to a requester index.
    always_comb begin
        int unsigned u;
        u = 32'(ptr_q) + 32'(enc_idx_c) + 1;
        if (u >= N) begin
            u = u - N;
        end
        win_idx_c = W'(u);
    end
`else
    assign enc_in_c  = cand_c;
    assign win_idx_c = enc_idx_c;
`endif

    prio_enc_n #(.N(N)) u_enc (
        .in_c  (enc_in_c),
        .idx_c (enc_idx_c),
        .any_c (enc_any_c)
    );

    // Next-state and next-grant logic.
    always_comb begin
        state_d        = state_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
`ifdef PRIO_ARB_RR_EN
        ptr_d          = ptr_q;
`endif
        if ((state_q == ST_IDLE) || bus.grant_ack) begin
            if (enc_any_c) begin
                state_d        = ST_GRANT;
                grant_valid_d  = 1'b1;
                grant_idx_d    = win_idx_c;
                grant_onehot_d = N'(idx_to_onehot(32'(win_idx_c), N));
`ifdef PRIO_ARB_RR_EN
                ptr_d          = (win_idx_c == '0) ? W'(N - 1) : win_idx_c - W'(1);
`endif
            end else if (state_q == ST_GRANT) begin
                state_d        = ST_IDLE;
                grant_valid_d  = 1'b0;
                grant_idx_d    = '0;
                grant_onehot_d = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            idle_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            idle_q         <= ~|bus.req;
        end
    end

`ifdef PRIO_ARB_RR_EN
    // Round-robin pointer; reset value makes the first pick match fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.idle         = idle_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Directed self-checking bench for prio_arbiter_n (N = 8), either build.
module tb_prio_arbiter_n;
    import prio_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    prio_arbiter_n_if #(.N(8)) bus ();

    prio_arbiter_n #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse with inputs quiet.
    task automatic apply_reset();
        bus.req       = '0;
        bus.grant_ack = 1'b0;
        rst_n         = 1'b0;
        #2;
        rst_n         = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.req = 8'hFF;
        step();
        n_cmp++;
        if (bus.grant_idx !== 3'd7) begin
            n_fail++;
            $display("FAIL reset_pre_idx: got %0d want 7", bus.grant_idx);
        end
        bus.grant_ack = 1'b1;
        step();
        bus.grant_ack = 1'b0;
        n_cmp++;
        if (bus.grant_idx !== 3'd6) begin
            n_fail++;
            $display("FAIL reset_pre_ack_idx: got %0d want 6", bus.grant_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async_grant: got valid=%0b idx=%0d want 0/0", bus.grant_valid, bus.grant_idx);
        end
        n_cmp++;
        if (bus.grant_onehot !== 8'h00 || bus.idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async_oh_idle: got oh=%h idle=%0b want 00/1", bus.grant_onehot, bus.idle);
        end
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7 || bus.grant_onehot !== 8'h80) begin
            n_fail++;
            $display("FAIL reset_first_grant: got valid=%0b idx=%0d oh=%h want 1/7/80", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
        n_cmp++;
        if (bus.idle !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after: got %0b want 0", bus.idle);
        end
    endtask

    task automatic test_fixed();
        apply_reset();
        bus.req = 8'hA4;
        step();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7 || bus.grant_onehot !== 8'h80) begin
            n_fail++;
            $display("FAIL fixed_first: got valid=%0b idx=%0d oh=%h want 1/7/80", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
        bus.req = 8'h04;
        step();
        step();
        n_cmp++;
        if (bus.grant_idx !== 3'd7 || bus.grant_onehot !== 8'h80 || bus.grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_hold: got valid=%0b idx=%0d oh=%h want 1/7/80", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
        bus.req       = 8'hA4;
        bus.grant_ack = 1'b1;
        step();
        bus.grant_ack = 1'b0;
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5 || bus.grant_onehot !== 8'h20) begin
            n_fail++;
            $display("FAIL fixed_ack_next: got valid=%0b idx=%0d oh=%h want 1/5/20", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
    endtask

    task automatic test_release();
        apply_reset();
        bus.req = 8'h01;
        step();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0 || bus.grant_onehot !== 8'h01) begin
            n_fail++;
            $display("FAIL release_first: got valid=%0b idx=%0d oh=%h want 1/0/01", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
        bus.grant_ack = 1'b1;
        step();
        bus.grant_ack = 1'b0;
        n_cmp++;
        if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 8'h00 || bus.grant_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL release_clear: got valid=%0b idx=%0d oh=%h want 0/0/00", bus.grant_valid, bus.grant_idx, bus.grant_onehot);
        end
        n_cmp++;
        if (dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL release_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        step();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL release_regrant: got valid=%0b idx=%0d want 1/0", bus.grant_valid, bus.grant_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_seq [9];
`ifdef PRIO_ARB_RR_EN
        exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        exp_seq = '{3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
`endif
        apply_reset();
        bus.req = 8'hFF;
        step();
        bus.grant_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got valid=%0b idx=%0d want 1/%0d", i, bus.grant_valid, bus.grant_idx, exp_seq[i]);
            end
            step();
        end
        bus.grant_ack = 1'b0;
    endtask

    task automatic test_fairness();
        logic [2:0] exp_81 [4];
        logic [2:0] exp_c1 [4];
        exp_81 = '{3'd7, 3'd0, 3'd7, 3'd0};
`ifdef PRIO_ARB_RR_EN
        exp_c1 = '{3'd7, 3'd6, 3'd0, 3'd7};
`else
        exp_c1 = '{3'd7, 3'd6, 3'd7, 3'd6};
`endif
        apply_reset();
        bus.req = 8'h81;
        step();
        bus.grant_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_81[i]) begin
                n_fail++;
                $display("FAIL fair_81[%0d]: got valid=%0b idx=%0d want 1/%0d", i, bus.grant_valid, bus.grant_idx, exp_81[i]);
            end
            step();
        end
        apply_reset();
        bus.req = 8'hC1;
        step();
        bus.grant_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_c1[i]) begin
                n_fail++;
                $display("FAIL fair_c1[%0d]: got valid=%0b idx=%0d want 1/%0d", i, bus.grant_valid, bus.grant_idx, exp_c1[i]);
            end
            step();
        end
        bus.grant_ack = 1'b0;
    endtask

    task automatic test_stray_ack();
        apply_reset();
        bus.req       = 8'h00;
        bus.grant_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.grant_onehot !== 8'h00 || bus.idle !== 1'b1) begin
                n_fail++;
                $display("FAIL stray_ack[%0d]: got valid=%0b idx=%0d oh=%h idle=%0b want 0/0/00/1", i, bus.grant_valid, bus.grant_idx, bus.grant_onehot, bus.idle);
            end
        end
        bus.grant_ack = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.grant_ack = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        test_reset();
        test_fixed();
        test_release();
        test_back_to_back();
        test_fairness();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
